// File: rtl/pwr_supply_clk_gen_multi.sv
// Multi-channel 50%-duty switching clock generator with per-channel phase offset,
// deferred half-period reload and glitch-free enable. Optional dither: PWR_SUPPLY_CLK_DITHER_EN.
module pwr_supply_clk_gen_multi #(
  parameter int unsigned NUM_CHANNELS        = 4,
  parameter int unsigned DIV_W               = 16,
  parameter int unsigned DEFAULT_HALF_PERIOD = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CHANNELS-1:0]       enable,
  input  logic [NUM_CHANNELS*DIV_W-1:0] half_period,
  input  logic [NUM_CHANNELS*DIV_W-1:0] phase_offset,
  input  logic                          cfg_load,
  output logic [NUM_CHANNELS-1:0]       pwr_supply_clk,
  output logic [NUM_CHANNELS-1:0]       running
);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

  localparam logic [DIV_W-1:0] HP_DEF = DIV_W'(DEFAULT_HALF_PERIOD);
  localparam logic [DIV_W-1:0] ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO    = DIV_W'(2);
  localparam logic [DIV_W:0]   ONE_W  = (DIV_W+1)'(1);

  function automatic logic [DIV_W-1:0] clamp_hp(input logic [DIV_W-1:0] v);
    return (v < TWO) ? TWO : v;
  endfunction

`ifdef PWR_SUPPLY_CLK_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_t           state_q, state_n;
    logic [DIV_W-1:0] cnt_q, cnt_n, h_q, h_n, p_q, p_n, pend_q, pend_n;
    logic             pvld_q, pvld_n, out_q, out_n, apply;
    logic [DIV_W:0]   h_eff, term;

`ifdef PWR_SUPPLY_CLK_DITHER_EN
    logic [1:0] d_q, d_n;

    // Dither code is latched on every rising output edge and held for the whole period.
    assign d_n = (out_n && !out_q) ? lfsr[2*c +: 2] : d_q;

    always_comb begin
      h_eff = {1'b0, h_q};
      case (d_q)
        2'b01:   h_eff = {1'b0, h_q} + ONE_W;
        2'b10:   h_eff = {1'b0, h_q} - ONE_W;
        default: h_eff = {1'b0, h_q};
      endcase
      if (h_eff < {1'b0, TWO}) h_eff = {1'b0, TWO};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_q <= '0;
      else        d_q <= d_n;
    end
`else
    assign h_eff = {1'b0, h_q};
`endif

    assign term = h_eff - ONE_W;

    always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      out_n   = out_q;
      h_n     = h_q;
      p_n     = p_q;
      pend_n  = pend_q;
      pvld_n  = pvld_q;
      apply   = 1'b0;
      case (state_q)
        IDLE: begin
          out_n = 1'b0;
          if (enable[c]) begin
            state_n = ALIGN;
            cnt_n   = '0;
            p_n     = phase_offset[c*DIV_W +: DIV_W];
            apply   = 1'b1;
          end
        end
        ALIGN: begin
          if (!enable[c]) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt_q == p_q) begin
            out_n   = 1'b1;
            cnt_n   = '0;
            state_n = RUN;
          end else begin
            cnt_n = cnt_q + ONE;
          end
        end
        RUN: begin
          // A disable during the low phase exits at once; during the high phase the
          // falling toggle is completed first so no runt pulse is produced.
          if (!enable[c] && !out_q) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if ({1'b0, cnt_q} == term) begin
            cnt_n = '0;
            out_n = !out_q;
            if (!out_q)          apply   = 1'b1;
            else if (!enable[c]) state_n = IDLE;
          end else begin
            cnt_n = cnt_q + ONE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          out_n   = 1'b0;
        end
      endcase
      if (apply && pvld_q) begin
        h_n    = pend_q;
        pvld_n = 1'b0;
      end
      // A load coinciding with an application wins: the fresh value stays pending.
      if (cfg_load) begin
        pend_n = clamp_hp(half_period[c*DIV_W +: DIV_W]);
        pvld_n = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        h_q     <= HP_DEF;
        p_q     <= '0;
        pend_q  <= HP_DEF;
        pvld_q  <= 1'b0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_n;
        cnt_q   <= cnt_n;
        h_q     <= h_n;
        p_q     <= p_n;
        pend_q  <= pend_n;
        pvld_q  <= pvld_n;
        out_q   <= out_n;
      end
    end

    assign pwr_supply_clk[c] = out_q;
    assign running[c]        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_pwr_supply_clk_gen_multi.sv
// Directed bench for pwr_supply_clk_gen_multi (default build, no dither).
module tb_pwr_supply_clk_gen_multi;
  localparam int unsigned NC = 4;
  localparam int unsigned DW = 16;
  localparam int BUDGET = 3000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NC-1:0]    enable = '0;
  logic [NC*DW-1:0] half_period = '0;
  logic [NC*DW-1:0] phase_offset = '0;
  logic             cfg_load = 1'b0;
  logic [NC-1:0]    pwr_supply_clk;
  logic [NC-1:0]    running;

  pwr_supply_clk_gen_multi #(
    .NUM_CHANNELS(NC),
    .DIV_W(DW),
    .DEFAULT_HALF_PERIOD(500)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .half_period(half_period),
    .phase_offset(phase_offset),
    .cfg_load(cfg_load),
    .pwr_supply_clk(pwr_supply_clk),
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hp;
    int ph;
    int exp_rise;
    int exp_high;
    int exp_low;
  } vec_t;

  vec_t vecs[6];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until channel ch reaches lvl; returns BUDGET+1 on timeout.
  task automatic wait_level(input int ch, input logic lvl, output int n);
    n = 0;
    while (pwr_supply_clk[ch] !== lvl && n <= BUDGET) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = '0;
    cfg_load = 1'b0;
    half_period = '0;
    phase_offset = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic load_all(input int hp);
    for (int c = 0; c < NC; c++) half_period[c*DW +: DW] = DW'(hp);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  initial begin
    int n;
    logic [NC-1:0] exp_v;

    vecs[0] = '{hp: 4,   ph: 0,  exp_rise: 1,  exp_high: 4,   exp_low: 4};
    vecs[1] = '{hp: 0,   ph: 3,  exp_rise: 4,  exp_high: 2,   exp_low: 2};
    vecs[2] = '{hp: 1,   ph: 0,  exp_rise: 1,  exp_high: 2,   exp_low: 2};
    vecs[3] = '{hp: 2,   ph: 5,  exp_rise: 6,  exp_high: 2,   exp_low: 2};
    vecs[4] = '{hp: 7,   ph: 1,  exp_rise: 2,  exp_high: 7,   exp_low: 7};
    vecs[5] = '{hp: 100, ph: 10, exp_rise: 11, exp_high: 100, exp_low: 100};

    // Reset state and default half period
    do_reset();
    check("reset_clk", int'(pwr_supply_clk), 0);
    check("reset_running", int'(running), 0);
    enable = 4'b0001;
    step();
    check("dflt_running", int'(running), 1);
    wait_level(0, 1'b1, n); check("dflt_rise", n, 1);
    wait_level(0, 1'b0, n); check("dflt_high", n, 500);
    wait_level(0, 1'b1, n); check("dflt_low", n, 500);

    // Table-driven single-channel cases: clamp, phase offset, period
    for (int i = 0; i < 6; i++) begin
      do_reset();
      load_all(vecs[i].hp);
      phase_offset[0 +: DW] = DW'(vecs[i].ph);
      enable = 4'b0001;
      step();
      check($sformatf("v%0d_running", i), int'(running[0]), 1);
      wait_level(0, 1'b1, n); check($sformatf("v%0d_rise", i), n, vecs[i].exp_rise);
      wait_level(0, 1'b0, n); check($sformatf("v%0d_high", i), n, vecs[i].exp_high);
      wait_level(0, 1'b1, n); check($sformatf("v%0d_low", i), n, vecs[i].exp_low);
    end

    // Four channels interleaved, H=4, offsets 0/2/4/6
    do_reset();
    load_all(4);
    for (int c = 0; c < NC; c++) phase_offset[c*DW +: DW] = DW'(2*c);
    enable = 4'hF;
    step();
    for (int k = 1; k <= 24; k++) begin
      step();
      for (int c = 0; c < NC; c++) begin
        int r;
        r = 2*c + 1;
        exp_v[c] = (k >= r) && (((k - r) % 8) < 4);
      end
      check($sformatf("ilv_k%0d", k), int'(pwr_supply_clk), int'(exp_v));
    end
    rst_n = 1'b0;
    #1;
    check("async_rst_clk", int'(pwr_supply_clk), 0);
    check("async_rst_running", int'(running), 0);
    #2;
    rst_n = 1'b1;

    // cfg_load during a high phase takes effect from the next rising edge
    do_reset();
    load_all(4);
    enable = 4'b0001;
    step();
    wait_level(0, 1'b1, n); check("reload_rise", n, 1);
    step();
    half_period[0 +: DW] = DW'(10);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    wait_level(0, 1'b0, n); check("reload_high_old", n, 2);
    wait_level(0, 1'b1, n); check("reload_low_old", n, 4);
    wait_level(0, 1'b0, n); check("reload_high_new", n, 10);
    wait_level(0, 1'b1, n); check("reload_low_new", n, 10);

    // Disable during high phase: completes the high phase, then idles
    do_reset();
    load_all(8);
    enable = 4'b0001;
    step();
    wait_level(0, 1'b1, n); check("dis_hi_rise", n, 1);
    step();
    step();
    enable = 4'b0000;
    wait_level(0, 1'b0, n); check("dis_hi_remaining", n, 6);
    check("dis_hi_running", int'(running[0]), 0);
    repeat (10) step();
    check("dis_hi_stays_low", int'(pwr_supply_clk[0]), 0);

    // Disable during low phase: idles on the next edge
    enable = 4'b0001;
    step();
    wait_level(0, 1'b1, n); check("dis_lo_rise", n, 1);
    wait_level(0, 1'b0, n); check("dis_lo_high", n, 8);
    step();
    step();
    enable = 4'b0000;
    step();
    check("dis_lo_running", int'(running[0]), 0);
    check("dis_lo_clk", int'(pwr_supply_clk[0]), 0);
    repeat (10) step();
    check("dis_lo_stays_low", int'(pwr_supply_clk[0]), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
